// File: rtl/custom_logic_pkg.sv
// Shared types and helpers for the custom_logic stream transform.
// Mode encoding plus the per-item beat count rule.
package custom_logic_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_EVEN_SQ = 2'd1,
    MODE_ALL_SQ  = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_t;

  // Only even items in MODE_EVEN_SQ repeat; everything else is a single beat.
  function automatic int beats_for(mode_t mode, logic lsb, int rep);
    if (mode == MODE_EVEN_SQ && !lsb) return rep;
    return 1;
  endfunction

endpackage

// File: rtl/custom_logic_xform.sv
// Combinational per-item transform: chooses pass-through or square and
// reports how many output beats the item occupies.
module custom_logic_xform
  import custom_logic_pkg::*;
#(
  parameter int DW  = 6,
  parameter int REP = 2,
  parameter int OW  = 2 * DW,
  parameter int BW  = $clog2(REP + 1)
) (
  input  mode_t            mode,
  input  logic [DW-1:0]    data,
  output logic [OW-1:0]    result,
  output logic [BW-1:0]    beats
);

  logic [2*DW-1:0] square;
  logic            do_square;

  // Square at full 2*DW precision, then resize to the output width.
  always_comb begin
    square    = {{DW{1'b0}}, data} * {{DW{1'b0}}, data};
    do_square = (mode == MODE_ALL_SQ) || ((mode == MODE_EVEN_SQ) && !data[0]);
    result    = do_square ? OW'(square) : OW'(data);
    beats     = BW'(beats_for(mode, data[0], REP));
  end

endmodule

// File: rtl/custom_logic_pipe.sv
// Registered odd/even stream transform between a valid/ready producer and consumer.
// One output register with a repeat counter; 1-cycle latency.
module custom_logic_pipe
  import custom_logic_pkg::*;
#(
  parameter int DW  = 6,
  parameter int REP = 2,
  parameter int OW  = 2 * DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] up_data,
  input  logic          up_valid,
  output logic          up_ready,
  output logic [OW-1:0] down_data,
  output logic          down_valid,
  input  logic          down_ready,
  output logic          busy
);

  localparam int RW = (REP > 1) ? $clog2(REP) : 1;
  localparam int BW = $clog2(REP + 1);

  logic [RW-1:0] rep_left;
  logic [OW-1:0] xf_result;
  logic [BW-1:0] xf_beats;
  logic [RW-1:0] rep_load;
  logic          accept;

  custom_logic_xform #(
    .DW  (DW),
    .REP (REP),
    .OW  (OW),
    .BW  (BW)
  ) u_xform (
    .mode   (mode_t'(mode)),
    .data   (up_data),
    .result (xf_result),
    .beats  (xf_beats)
  );

  // The last pending beat leaving this cycle frees the register for a new item.
  assign up_ready = ~down_valid | (down_ready & (rep_left == '0));
  assign accept   = up_valid & up_ready;
  assign rep_load = RW'(xf_beats - BW'(1));
  assign busy     = down_valid | (rep_left != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_data  <= '0;
      down_valid <= 1'b0;
      rep_left   <= '0;
    end else if (accept) begin
      down_data  <= xf_result;
      down_valid <= 1'b1;
      rep_left   <= rep_load;
    end else if (down_valid && down_ready) begin
      if (rep_left != '0) begin
        rep_left <= rep_left - RW'(1);
      end else begin
        down_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_custom_logic_pipe.sv
// Directed scoreboard bench for custom_logic_pipe (DW=6, REP=2, OW=12).
module tb_custom_logic_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [5:0]  up_data;
  logic        up_valid;
  logic        up_ready;
  logic [11:0] down_data;
  logic        down_valid;
  logic        down_ready;
  logic        busy;

  int n_compared   = 0;
  int n_mismatched = 0;
  int beats_seen   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  custom_logic_pipe #(.DW(6), .REP(2), .OW(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .down_data  (down_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .busy       (busy)
  );

  function automatic int model_value(int m, int d);
    if (m == 2 || (m == 1 && (d % 2) == 0)) return d * d;
    return d;
  endfunction

  function automatic int model_beats(int m, int d);
    if (m == 1 && (d % 2) == 0) return 2;
    return 1;
  endfunction

  task automatic compare(input string tag, input int observed, input int expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [1:0] m, input logic [5:0] d,
                                input logic r);
    up_valid   = v;
    mode       = m;
    up_data    = d;
    down_ready = r;
  endtask

  // Pop and check a taken beat, then record the item accepted this cycle.
  task automatic check_output();
    if (down_valid && down_ready) begin
      compare("beat_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        compare("beat_data", int'(down_data), exp_q[0]);
        void'(exp_q.pop_front());
      end
      beats_seen++;
    end
    if (up_valid && up_ready && !rst) begin
      for (int k = 0; k < model_beats(int'(mode), int'(up_data)); k++)
        exp_q.push_back(model_value(int'(mode), int'(up_data)));
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_output();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    sample();
    compare({tag, "_valid"}, int'(down_valid), 0);
    compare({tag, "_busy"}, int'(busy), 0);
    compare({tag, "_drained"}, exp_q.size(), 0);
    advance();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int items[4];
    int start_beats;
    items = '{1, 3, 5, 7};

    rst = 1'b1;
    apply_stimulus(1'b0, 2'd0, 6'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    compare("rst_valid", int'(down_valid), 0);
    compare("rst_data", int'(down_data), 0);
    compare("rst_busy", int'(busy), 0);
    advance();
    rst = 1'b0;
    sample();
    compare("rst_ready", int'(up_ready), 1);
    advance();

    $display("[TB] test 1: even repeat");
    apply_stimulus(1'b1, 2'd1, 6'd5, 1'b1);
    sample(); compare("t1_ready_5", int'(up_ready), 1); advance();
    apply_stimulus(1'b1, 2'd1, 6'd6, 1'b1);
    sample(); compare("t1_ready_6", int'(up_ready), 1); advance();
    apply_stimulus(1'b0, 2'd1, 6'($urandom_range(0, 63)), 1'b1);
    sample();
    compare("t1_ready_rep", int'(up_ready), 0);
    compare("t1_busy", int'(busy), 1);
    advance();
    sample(); compare("t1_ready_last", int'(up_ready), 1); advance();
    check_idle("t1");

    $display("[TB] test 2: all-square and pass");
    apply_stimulus(1'b1, 2'd2, 6'd63, 1'b1);
    sample(); advance();
    apply_stimulus(1'b1, 2'd0, 6'd62, 1'b1);
    sample(); compare("t2_busy", int'(busy), 1); advance();
    apply_stimulus(1'b0, 2'd0, 6'($urandom_range(0, 63)), 1'b1);
    sample(); advance();
    check_idle("t2");

    $display("[TB] test 3: back-to-back odd items");
    start_beats = beats_seen;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 2'd1, 6'(items[i]), 1'b1);
      sample();
      compare("t3_ready", int'(up_ready), 1);
      if (i > 0) compare("t3_valid", int'(down_valid), 1);
      advance();
    end
    apply_stimulus(1'b0, 2'd1, 6'($urandom_range(0, 63)), 1'b1);
    sample(); compare("t3_valid_last", int'(down_valid), 1); advance();
    compare("t3_beats", beats_seen - start_beats, 4);
    check_idle("t3");

    $display("[TB] test 4: backpressure");
    apply_stimulus(1'b1, 2'd1, 6'd4, 1'b1);
    sample(); advance();
    apply_stimulus(1'b0, 2'd1, 6'($urandom_range(0, 63)), 1'b0);
    for (int i = 0; i < 5; i++) begin
      sample();
      compare("t4_hold_data", int'(down_data), 16);
      compare("t4_hold_valid", int'(down_valid), 1);
      compare("t4_hold_ready", int'(up_ready), 0);
      advance();
    end
    start_beats = beats_seen;
    apply_stimulus(1'b0, 2'd1, 6'($urandom_range(0, 63)), 1'b1);
    sample(); advance();
    sample(); advance();
    compare("t4_beats", beats_seen - start_beats, 2);
    check_idle("t4");

    $display("[TB] test 5: mode change while repeating");
    apply_stimulus(1'b1, 2'd1, 6'd4, 1'b1);
    sample(); advance();
    apply_stimulus(1'b1, 2'd0, 6'd4, 1'b1);
    sample(); compare("t5_ready_rep", int'(up_ready), 0); advance();
    sample(); compare("t5_ready_free", int'(up_ready), 1); advance();
    apply_stimulus(1'b0, 2'd0, 6'($urandom_range(0, 63)), 1'b1);
    sample(); advance();
    check_idle("t5");

    $display("[TB] test 6: reset mid-repeat");
    apply_stimulus(1'b1, 2'd1, 6'd8, 1'b1);
    sample(); advance();
    apply_stimulus(1'b0, 2'd1, 6'($urandom_range(0, 63)), 1'b1);
    sample(); advance();
    rst = 1'b1;
    #1;
    compare("t6_rst_valid", int'(down_valid), 0);
    compare("t6_rst_busy", int'(busy), 0);
    exp_q.delete();
    advance();
    rst = 1'b0;
    sample(); compare("t6_ready", int'(up_ready), 1); advance();
    apply_stimulus(1'b1, 2'd1, 6'd3, 1'b1);
    sample(); advance();
    apply_stimulus(1'b0, 2'd1, 6'($urandom_range(0, 63)), 1'b1);
    sample(); compare("t6_data", int'(down_data), 3); advance();
    check_idle("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
